// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester round-robin arbiter and sequencer for a single-port SRAM
module sram_arbiter #(
  parameter int addr_width = 12,
  parameter int word_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [addr_width-1:0] a_addr,
  input  logic [word_width-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [word_width-1:0] a_rdata,

  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [addr_width-1:0] b_addr,
  input  logic [word_width-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [word_width-1:0] b_rdata,

  output logic [addr_width-1:0] mem_addr,
  output logic [word_width-1:0] mem_din,
  output logic                  mem_we,
  input  logic [word_width-1:0] mem_dout,

  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // ptr_b is the last-grant pointer (1 = B). It is only updated on a grant,
  // so while a read is in flight it also names the owner of the read data.
  logic                  ptr_b, ptr_b_nxt;
  logic                  win_b;

  logic                  a_gnt_nxt, b_gnt_nxt;
  logic                  a_rvalid_nxt, b_rvalid_nxt;
  logic [word_width-1:0] a_rdata_nxt, b_rdata_nxt;
  logic [addr_width-1:0] mem_addr_nxt;
  logic [word_width-1:0] mem_din_nxt;
  logic                  mem_we_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration, sequencing and next values of every registered output
  always_comb begin
    state_nxt    = state;
    ptr_b_nxt    = ptr_b;
    a_gnt_nxt    = 1'b0;
    b_gnt_nxt    = 1'b0;
    a_rvalid_nxt = 1'b0;
    b_rvalid_nxt = 1'b0;
    a_rdata_nxt  = a_rdata;
    b_rdata_nxt  = b_rdata;
    mem_addr_nxt = mem_addr;
    mem_din_nxt  = mem_din;
    mem_we_nxt   = 1'b1;
    // B wins when it is alone, or when both ask and A was granted last
    win_b        = b_req & (~a_req | ~ptr_b);

    case (state)
      IDLE: begin
        if (a_req | b_req) begin
          state_nxt = ACCESS;
          ptr_b_nxt = win_b;
          if (win_b) begin
            b_gnt_nxt    = 1'b1;
            mem_addr_nxt = b_addr;
            mem_din_nxt  = b_wdata;
            mem_we_nxt   = ~b_wr;
          end else begin
            a_gnt_nxt    = 1'b1;
            mem_addr_nxt = a_addr;
            mem_din_nxt  = a_wdata;
            mem_we_nxt   = ~a_wr;
          end
        end
      end

      ACCESS: begin
        // The command on the pins is sampled by the SRAM at this edge;
        // a write is finished, a read needs one more cycle for dout.
        state_nxt = mem_we ? RDATA : IDLE;
      end

      RDATA: begin
        state_nxt = IDLE;
        if (ptr_b) begin
          b_rvalid_nxt = 1'b1;
          b_rdata_nxt  = mem_dout;
        end else begin
          a_rvalid_nxt = 1'b1;
          a_rdata_nxt  = mem_dout;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output and pointer registers; reset leaves the SRAM in read mode
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_b    <= 1'b1;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b1;
    end else begin
      ptr_b    <= ptr_b_nxt;
      a_gnt    <= a_gnt_nxt;
      b_gnt    <= b_gnt_nxt;
      a_rvalid <= a_rvalid_nxt;
      b_rvalid <= b_rvalid_nxt;
      a_rdata  <= a_rdata_nxt;
      b_rdata  <= b_rdata_nxt;
      mem_addr <= mem_addr_nxt;
      mem_din  <= mem_din_nxt;
      mem_we   <= mem_we_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with SRAM model and transaction-level reference
module tb_sram_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_wr, b_req, b_wr;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_we;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.addr_width(AW), .word_width(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_wr     (a_wr),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_wr     (b_wr),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

  // SRAM: active-low write enable, registered read data, bench preload port
  logic [DW-1:0] sram [4096];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    else if (!mem_we) sram[mem_addr] <= mem_din;
    else mem_dout <= sram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: commands are scheduled by occupancy time, memory is a shadow array
  logic [DW-1:0] shadow [4096];
  bit            model_ok = 0;
  int            cyc = 0;
  int            free_cyc = 0;
  bit            ret_pend = 0;
  int            ret_cyc = 0;
  bit            ret_b = 0;
  logic [DW-1:0] ret_data = '0;
  bit            last_b = 1;
  bit            win_b;
  logic          e_a_gnt, e_b_gnt, e_a_rvalid, e_b_rvalid, e_mem_we, e_busy;
  logic [DW-1:0] e_a_rdata, e_b_rdata, e_mem_din;
  logic [AW-1:0] e_mem_addr;

  initial for (int i = 0; i < 4096; i++) shadow[i] = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      model_ok   = 1;
      free_cyc   = cyc + 1;
      ret_pend   = 0;
      last_b     = 1;
      e_a_gnt    = 0; e_b_gnt = 0; e_a_rvalid = 0; e_b_rvalid = 0;
      e_a_rdata  = '0; e_b_rdata = '0;
      e_mem_addr = '0; e_mem_din = '0; e_mem_we = 1;
    end else begin
      e_a_gnt = 0; e_b_gnt = 0; e_a_rvalid = 0; e_b_rvalid = 0; e_mem_we = 1;
      if (ret_pend && ret_cyc == cyc) begin
        ret_pend = 0;
        if (ret_b) begin e_b_rvalid = 1; e_b_rdata = ret_data; end
        else begin e_a_rvalid = 1; e_a_rdata = ret_data; end
      end
      if (cyc >= free_cyc && (a_req || b_req)) begin
        win_b  = b_req && (!a_req || !last_b);
        last_b = win_b;
        if (win_b) begin e_b_gnt = 1; e_mem_addr = b_addr; e_mem_din = b_wdata; e_mem_we = !b_wr; end
        else begin e_a_gnt = 1; e_mem_addr = a_addr; e_mem_din = a_wdata; e_mem_we = !a_wr; end
        if (!e_mem_we) begin
          shadow[e_mem_addr] = e_mem_din;
          free_cyc = cyc + 2;
        end else begin
          ret_pend = 1; ret_cyc = cyc + 2; ret_b = win_b; ret_data = shadow[e_mem_addr];
          free_cyc = cyc + 3;
        end
      end
    end
    e_busy = (cyc + 1 < free_cyc);
  end

  // Per-cycle comparison against the reference model
  always @(negedge clk) begin
    if (model_ok) begin
      chk("a_gnt", a_gnt, e_a_gnt);
      chk("b_gnt", b_gnt, e_b_gnt);
      chk("a_rvalid", a_rvalid, e_a_rvalid);
      chk("b_rvalid", b_rvalid, e_b_rvalid);
      chk("a_rdata", a_rdata, e_a_rdata);
      chk("b_rdata", b_rdata, e_b_rdata);
      chk("mem_addr", mem_addr, e_mem_addr);
      chk("mem_din", mem_din, e_mem_din);
      chk("mem_we", mem_we, e_mem_we);
      chk("busy", busy, e_busy);
    end
  end

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    pl_addr = addr; pl_data = data; pl_en = 1'b1;
    shadow[addr] = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic cmd(input bit on_b, input bit wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, output int lat);
    bit got;
    got = 0;
    lat = -1;
    if (on_b) begin b_wr = wr; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
    else begin a_wr = wr; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (on_b ? b_gnt : a_gnt) begin
        got = 1;
        lat = i;
        if (on_b) b_req = 1'b0; else a_req = 1'b0;
      end
    end
    if (!got) begin
      chk("gnt_timeout", 0, 1);
      a_req = 1'b0; b_req = 1'b0;
    end
  endtask

  task automatic wait_rvalid(input bit on_b, output int lat, output logic [DW-1:0] d);
    bit got;
    got = 0;
    lat = -1;
    d = '0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (on_b ? b_rvalid : a_rvalid) begin
        got = 1;
        lat = i;
        d = on_b ? b_rdata : a_rdata;
      end
    end
    if (!got) chk("rvalid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    if (!got) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int            lat;
    logic [DW-1:0] d;
    int            ng, na, nb;
    int            gcyc [4];
    logic [3:0]    seq;
    int            first;
    bit            a_open, b_open;

    rst = 1'b1;
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (10) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_we", mem_we, 1);
    chk("idle_pulses", {a_gnt, b_gnt, a_rvalid, b_rvalid}, 4'b0000);

    // A write then read of the same address
    cmd(0, 1, 12'h005, 16'h1234, lat);
    chk("a_wr_gnt_lat", lat, 1);
    wait_idle();
    cmd(0, 0, 12'h005, 16'h0000, lat);
    chk("a_rd_gnt_lat", lat, 1);
    wait_rvalid(0, lat, d);
    chk("a_rd_lat", lat, 2);
    chk("a_rd_data", d, 16'h1234);
    chk("b_rdata_untouched", b_rdata, 16'h0000);

    // Continuous contention after reset: A, B, A, B with 3-cycle spacing
    do_reset();
    preload(12'h010, 16'hAAAA);
    preload(12'hFFF, 16'h5555);
    a_wr = 0; a_addr = 12'h010; b_wr = 0; b_addr = 12'hFFF;
    a_req = 1'b1; b_req = 1'b1;
    ng = 0; na = 0; nb = 0; seq = '0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (a_gnt) begin
        seq = {seq[2:0], 1'b0}; gcyc[ng] = i; ng++; na++;
        if (na == 2) a_req = 1'b0;
      end
      if (b_gnt) begin
        seq = {seq[2:0], 1'b1}; gcyc[ng] = i; ng++; nb++;
        if (nb == 2) b_req = 1'b0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("cont_grants", ng, 4);
    chk("cont_order", seq, 4'b0101);
    if (ng == 4) begin
      chk("cont_gap1", gcyc[1] - gcyc[0], 3);
      chk("cont_gap2", gcyc[2] - gcyc[1], 3);
      chk("cont_gap3", gcyc[3] - gcyc[2], 3);
    end
    repeat (6) @(negedge clk);
    chk("cont_a_data", a_rdata, 16'hAAAA);
    chk("cont_b_data", b_rdata, 16'h5555);

    // Pointer favours B: B write and A read of 0x020 in the same cycle
    cmd(0, 0, 12'h010, 16'h0000, lat);
    wait_rvalid(0, lat, d);
    a_wr = 0; a_addr = 12'h020; a_wdata = '0;
    b_wr = 1; b_addr = 12'h020; b_wdata = 16'hBEEF;
    a_req = 1'b1; b_req = 1'b1;
    first = -1; a_open = 1; b_open = 1;
    for (int i = 0; i < 20 && (a_open || b_open); i++) begin
      @(negedge clk);
      if (b_gnt) begin if (first < 0) first = 1; b_req = 1'b0; b_open = 0; end
      if (a_gnt) begin if (first < 0) first = 0; a_req = 1'b0; a_open = 0; end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("raw_first_b", first, 1);
    wait_rvalid(0, lat, d);
    chk("raw_a_data", d, 16'hBEEF);

    // Reset during RDATA suppresses rvalid and clears rdata
    cmd(0, 0, 12'h005, 16'h0000, lat);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_rvalid", a_rvalid, 0);
    chk("rst_rd_rdata", a_rdata, 16'h0000);
    chk("rst_rd_busy", busy, 0);
    rst = 1'b0;
    cmd(0, 0, 12'h005, 16'h0000, lat);
    wait_rvalid(0, lat, d);
    chk("rst_rd_again", d, 16'h1234);

    // Reset on the edge ending a write's ACCESS still commits the write
    cmd(0, 1, 12'h030, 16'h7777, lat);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_busy", busy, 0);
    chk("rst_wr_we", mem_we, 1);
    rst = 1'b0;
    cmd(0, 0, 12'h030, 16'h0000, lat);
    wait_rvalid(0, lat, d);
    chk("rst_wr_commit", d, 16'h7777);

    // Reset overriding a request in IDLE issues no command
    rst = 1'b1;
    a_wr = 1; a_addr = 12'h040; a_wdata = 16'h9999; a_req = 1'b1;
    @(negedge clk);
    chk("rst_req_gnt", a_gnt, 0);
    chk("rst_req_we", mem_we, 1);
    a_req = 1'b0;
    rst = 1'b0;

    // B read at the top address
    cmd(1, 0, 12'hFFF, 16'h0000, lat);
    chk("b_rd_gnt_lat", lat, 1);
    wait_rvalid(1, lat, d);
    chk("b_rd_top", d, 16'h5555);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
